// File: rtl/dbus_responder.sv
// Data-bus target backed by a word-addressed RAM with fixed response latency.
// One transaction in flight; byte-strobed stores commit on the edge that ends RESP.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

// state | meaning
// IDLE  | ready; addr_ok follows dreq.valid, a valid request is accepted
// WAIT  | latency countdown; dropping valid abandons the transaction
// RESP  | data_ok for one cycle; a write commits on the closing edge
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          LATENCY = 2,
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        busy,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept;
  logic [63:0]     req_off;
  logic            req_hit;
  logic [AW-1:0]   req_idx;
  logic            hit_q;
  logic [AW-1:0]   idx_q;
  logic [7:0]      strobe_q;
  logic [63:0]     wdata_q;
  logic [63:0]     rdata_q;
  logic [63:0]     mem [DEPTH];
  logic            unused_size;

  // Size is informational only; the strobe alone selects written bytes.
  assign unused_size = ^dreq.size;

  assign req_off = dreq.addr - BASE;
  assign req_hit = (dreq.addr >= BASE) && (req_off < SPAN);
  assign req_idx = req_off[AW+2:3];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (dreq.valid) begin
          accept    = 1'b1;
          cnt_nxt   = 4'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!dreq.valid)   state_nxt = IDLE;
        else if (cnt == 4'd1) state_nxt = RESP;
        else               cnt_nxt = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = (state == IDLE) && dreq.valid;
    dresp.data_ok = (state == RESP);
    dresp.data    = ((state == RESP) && (strobe_q == 8'h00)) ? rdata_q : 64'h0;
  end

  assign busy = (state != IDLE);

  // Read data is captured at acceptance: with one outstanding transaction no
  // store can land between acceptance and RESP, so the word is still current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      strobe_q <= 8'h00;
      wdata_q  <= 64'h0;
      rdata_q  <= 64'h0;
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        hit_q    <= req_hit;
        idx_q    <= req_idx;
        strobe_q <= dreq.strobe;
        wdata_q  <= dreq.data;
        rdata_q  <= req_hit ? mem[req_idx] : 64'h0;
      end
      if (state == RESP) begin
        if (strobe_q != 8'h00) wr_count <= wr_count + 32'd1;
        else                   rd_count <= rd_count + 32'd1;
      end
    end
  end

  // RAM has no reset; an asynchronous reset forces IDLE so nothing commits.
  always_ff @(posedge clk) begin
    if ((state == RESP) && hit_q) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboard bench for dbus_responder at LATENCY 2, 4 and 1.
// Drivers push expected response data; a negedge monitor pops on every data_ok.
module tb_dbus_responder;
  import dbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  dbus_req_t   dreq [3];
  dbus_resp_t  dresp [3];
  logic        busy [3];
  logic [31:0] rd_count [3];
  logic [31:0] wr_count [3];

  int lat [3] = '{2, 4, 1};
  int exp_rd [3];
  int exp_wr [3];
  int checks = 0;
  int errors = 0;
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [63:0] q2 [$];

  always #5 clk = ~clk;

  dbus_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .dreq(dreq[0]), .dresp(dresp[0]),
    .busy(busy[0]), .rd_count(rd_count[0]), .wr_count(wr_count[0]));
  dbus_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .dreq(dreq[1]), .dresp(dresp[1]),
    .busy(busy[1]), .rd_count(rd_count[1]), .wr_count(wr_count[1]));
  dbus_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .dreq(dreq[2]), .dresp(dresp[2]),
    .busy(busy[2]), .rd_count(rd_count[2]), .wr_count(wr_count[2]));

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (dresp[0].data_ok) begin
      if (q0.size() == 0) check("l2 unexpected data_ok", dresp[0].data_ok, 0);
      else                check("l2 resp data", dresp[0].data, q0.pop_front());
    end
    if (dresp[1].data_ok) begin
      if (q1.size() == 0) check("l4 unexpected data_ok", dresp[1].data_ok, 0);
      else                check("l4 resp data", dresp[1].data, q1.pop_front());
    end
    if (dresp[2].data_ok) begin
      if (q2.size() == 0) check("l1 unexpected data_ok", dresp[2].data_ok, 0);
      else                check("l1 resp data", dresp[2].data, q2.pop_front());
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge closing RESP with
  // valid still high, so back-to-back calls keep valid asserted continuously.
  task automatic txn(input int k, input logic [63:0] addr, input logic [7:0] strb,
                     input logic [63:0] wdata, input logic [63:0] exp);
    logic [63:0] e;
    e = (strb != 8'h00) ? 64'h0 : exp;
    dreq[k].valid  = 1'b1;
    dreq[k].addr   = addr;
    dreq[k].size   = 3'd3;
    dreq[k].strobe = strb;
    dreq[k].data   = wdata;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    if (strb != 8'h00) exp_wr[k]++;
    else               exp_rd[k]++;
    @(negedge clk);
    check($sformatf("lat%0d addr_ok at accept %h", lat[k], addr), dresp[k].addr_ok, 1);
    for (int c = 1; c <= lat[k]; c++) begin
      @(negedge clk);
      check($sformatf("lat%0d data_ok cycle %0d", lat[k], c), dresp[k].data_ok, c == lat[k]);
      check($sformatf("lat%0d busy cycle %0d", lat[k], c), busy[k], 1);
      check($sformatf("lat%0d addr_ok held low %0d", lat[k], c), dresp[k].addr_ok, 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    dreq[k] = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input int k);
    check($sformatf("lat%0d rd_count", lat[k]), rd_count[k], 64'(exp_rd[k]));
    check($sformatf("lat%0d wr_count", lat[k]), wr_count[k], 64'(exp_wr[k]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      dreq[k] = '0;
      exp_rd[k] = 0;
      exp_wr[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy[0], 0);
    check("reset data_ok", dresp[0].data_ok, 0);
    check("reset addr_ok", dresp[0].addr_ok, 0);
    check("reset data", dresp[0].data, 0);
    chk_counts(0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // LATENCY=2: timing, partial stores, range boundaries
    txn(0, 64'h8000_0000, 8'hFF, 64'h1122_3344_5566_7788, 64'h0); idle(0);
    txn(0, 64'h8000_0000, 8'h00, 64'h0, 64'h1122_3344_5566_7788); idle(0);
    check("lat2 rd_count after first read", rd_count[0], 1);
    txn(0, 64'h8000_0008, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0); idle(0);
    txn(0, 64'h8000_0008, 8'h0F, 64'hDEAD_BEEF_CAFE_BABE, 64'h0); idle(0);
    txn(0, 64'h8000_0008, 8'h00, 64'h0, 64'hFFFF_FFFF_CAFE_BABE); idle(0);
    txn(0, 64'h8000_000D, 8'h20, 64'h0000_AB00_0000_0000, 64'h0); idle(0);
    txn(0, 64'h8000_0008, 8'h00, 64'h0, 64'hFFFF_ABFF_CAFE_BABE); idle(0);
    chk_counts(0);
    txn(0, 64'h0000_1000, 8'h00, 64'h0, 64'h0); idle(0);
    txn(0, 64'h9000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0); idle(0);
    txn(0, 64'h8000_0000, 8'h00, 64'h0, 64'h1122_3344_5566_7788); idle(0);
    txn(0, 64'h8000_1FF8, 8'hFF, 64'h5555_6666_7777_8888, 64'h0); idle(0);
    txn(0, 64'h8000_1FF8, 8'h00, 64'h0, 64'h5555_6666_7777_8888); idle(0);
    txn(0, 64'h8000_2000, 8'h00, 64'h0, 64'h0); idle(0);
    chk_counts(0);

    // LATENCY=4: normal round trip, then abort of a write in WAIT
    txn(1, 64'h8000_0010, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0); idle(1);
    txn(1, 64'h8000_0010, 8'h00, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5); idle(1);
    dreq[1].valid  = 1'b1;
    dreq[1].addr   = 64'h8000_0010;
    dreq[1].size   = 3'd3;
    dreq[1].strobe = 8'hFF;
    dreq[1].data   = 64'h5A5A_5A5A_5A5A_5A5A;
    @(negedge clk);
    check("abort addr_ok at accept", dresp[1].addr_ok, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    dreq[1].valid = 1'b0;
    @(negedge clk);
    check("abort busy in WAIT", busy[1], 1);
    @(posedge clk); #1;
    check("abort back to idle", busy[1], 0);
    txn(1, 64'h8000_0010, 8'h00, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5); idle(1);
    chk_counts(1);

    // LATENCY=1: write then read with valid held continuously
    txn(2, 64'h8000_0020, 8'hFF, 64'h0F1E_2D3C_4B5A_6978, 64'h0);
    txn(2, 64'h8000_0020, 8'h00, 64'h0, 64'h0F1E_2D3C_4B5A_6978);
    idle(2);
    chk_counts(2);

    // Reset in the middle of a LATENCY=2 write to word 0
    dreq[0].valid  = 1'b1;
    dreq[0].addr   = 64'h8000_0000;
    dreq[0].size   = 3'd3;
    dreq[0].strobe = 8'hFF;
    dreq[0].data   = 64'hDEAD_0000_0000_BAD0;
    @(negedge clk);
    check("midreset addr_ok", dresp[0].addr_ok, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midreset busy", busy[0], 0);
    check("midreset data_ok", dresp[0].data_ok, 0);
    for (int k = 0; k < 3; k++) begin
      exp_rd[k] = 0;
      exp_wr[k] = 0;
      chk_counts(k);
    end
    dreq[0] = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    txn(0, 64'h8000_0000, 8'h00, 64'h0, 64'h1122_3344_5566_7788); idle(0);
    txn(0, 64'h8000_0008, 8'h00, 64'h0, 64'hFFFF_ABFF_CAFE_BABE); idle(0);
    chk_counts(0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", 64'(q0.size() + q1.size() + q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Data-bus target that answers `dbus_req_t` requests from the memory stage with `dbus_resp_t` responses.
- Backed by an internal word-addressed RAM with a fixed, parameterised latency.
- Used as the simulation/FPGA memory model behind the pipeline's data port and as the checker-facing end of the dbus handshake.
- Handles one outstanding transaction at a time; stores obey the byte strobe.

Parameters:
- LATENCY, 2: cycles from acceptance (`addr_ok`) to `data_ok`; legal range 1..15.
- DEPTH, 1024: number of 64-bit words in the backing RAM (power of two).
- BASE, 64'h8000_0000: byte address of word 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- dreq  input  dbus_req_t  request from the initiator: valid, addr, size, strobe, data.
- dresp  output  dbus_resp_t  response to the initiator: addr_ok, data_ok, data.
- busy  output  1  high while a transaction is accepted but not yet answered.
- rd_count  output  32  number of completed reads.
- wr_count  output  32  number of completed writes (strobe != 0).

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; counter=0; latched request cleared.
  - `dresp.addr_ok`, `dresp.data_ok`, `busy` = 0; `dresp.data` = 0; `rd_count` = `wr_count` = 0.
  - RAM contents are not cleared.
- Reset asserted mid-transaction: the transaction is dropped, any pending write is not committed, and the FSM is back in IDLE after rst releases.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `addr_ok` = `dreq.valid` (combinational).
  - If valid: latch addr, size, strobe, data; load counter = LATENCY-1; next state = RESP if LATENCY==1, else WAIT.
- WAIT:
  - `busy`=1; counter decrements each cycle; when counter reaches 1, next state = RESP.
  - If `dreq.valid` drops: abandon, return to IDLE, no commit, no `data_ok`.
- RESP:
  - `busy`=1; `data_ok`=1 for exactly this one cycle.
  - Next state = IDLE.
  - The initiator keeps valid high through this cycle and may present a new request in the following cycle.
- Timing: acceptance at cycle T gives `data_ok` at cycle T+LATENCY. Back-to-back throughput is one transaction per LATENCY+1 cycles.
- Address decode:
  - In range when BASE <= addr < BASE + 8*DEPTH.
  - word index = (addr - BASE) >> 3, i.e. the low 3 address bits select the byte lane only.
- Reads (strobe == 0):
  - `dresp.data` = full aligned 64-bit word, sampled in the RESP cycle. Lane extraction and sign extension belong to the initiator.
  - Out-of-range reads return 64'h0.
  - `rd_count` increments at the end of RESP.
- Writes (strobe != 0):
  - Byte i is written from `data[8i+7:8i]` where `strobe[i]`=1.
  - Commit happens on the clock edge ending RESP.
  - `dresp.data` = 0 during a write response.
  - Out-of-range writes are dropped but still answered with `data_ok`.
  - `wr_count` increments at the end of RESP.
- Alignment: size is not checked against addr; the strobe alone defines which bytes are written.
- Read-after-write: a read accepted after a write's RESP cycle observes the committed bytes.
- `addr_ok` is 0 in WAIT and RESP; requests are not queued.
- Counters wrap modulo 2^32.
- Outputs other than `addr_ok` are registered or decoded from state; there is no combinational path from `dreq` to `data_ok` or `data`.

Test Plan:
- LATENCY=2 timing: preload word 0 = 64'h1122334455667788; read addr 0x8000_0000 accepted at cycle T -> `addr_ok`=1 at T, `data_ok`=1 only at T+2 with data 64'h1122334455667788; `rd_count`=1.
- Partial store: write addr 0x8000_0008, strobe 8'h0F, data 64'hDEADBEEF_CAFEBABE over old 64'hFFFF_FFFF_FFFF_FFFF -> a subsequent read returns 64'hFFFFFFFF_CAFEBABE; `wr_count`=1.
- Out-of-range: read 0x0000_1000 -> `data_ok` after LATENCY with data 0; write 0x9000_0000 -> acknowledged, RAM unchanged, `wr_count` increments.
- Abort: with LATENCY=4, accept a write then drop valid at T+2 -> no `data_ok`, target word unchanged, FSM returns to IDLE, and the next request gets `addr_ok` the same cycle.
- Reset mid-operation: pull rst low at T+1 of a write -> `busy`/`data_ok`=0 immediately, counters=0, word unchanged, earlier RAM data retained.
- Back-to-back, LATENCY=1: write then read of the same address with valid held continuously -> `data_ok` in cycles 1 and 3, and the read returns the just-written data.
